avalon_multi_timer: RTL and testbench



---
 rtl/avalon_multi_timer.sv | 189 ++++++++++++++++++
 tb/tb_avalon_multi_timer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_multi_timer.sv
// Multi-channel interval timer behind a 32-bit Avalon-MM slave: each channel has a prescaler,
// one-shot/continuous down-counter, PWM compare output, snapshot register and overrun flag.
module avalon_multi_timer #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int PRESC_W      = 8,
  parameter int RESET_PERIOD = 49999
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [$clog2(NUM_CH)+2:0]  address,
  input  logic                       chipselect,
  input  logic                       write_n,
  input  logic                       read_n,
  input  logic [31:0]                writedata,
  output logic [31:0]                readdata,
  output logic                       irq,
  output logic [NUM_CH-1:0]          irq_vec,
  output logic [NUM_CH-1:0]          pwm_out
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0]   RST_CNT    = CNT_W'(RESET_PERIOD);
  localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [PRESC_W-1:0] PRESC_ZERO = {PRESC_W{1'b0}};
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);

  logic [CH_W-1:0] ch_sel_s;
  logic [2:0]      reg_sel_s;
  logic            wr_s;
  logic [31:0]     ch_rdata_s [NUM_CH];
  logic [31:0]     rd_sel_s;
  logic [31:0]     readdata_q;
  logic            unused_ok;

  // read_n is informational only: readdata is refreshed every cycle.
  assign unused_ok = ^{read_n, writedata};
  assign reg_sel_s = address[2:0];
  assign wr_s      = chipselect & ~write_n;

  if (NUM_CH > 1) begin : g_multi
    assign ch_sel_s = address[$clog2(NUM_CH)+2:3];
    assign rd_sel_s = ch_rdata_s[ch_sel_s];
  end else begin : g_single
    assign ch_sel_s = 1'b0;
    assign rd_sel_s = ch_rdata_s[0];
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic               sel_s, wr_status_s, wr_ctrl_s, wr_period_s, wr_cmp_s, wr_snap_s, wr_presc_s;
    logic               start_s, stop_s, tick_s, te_s;
    logic [CNT_W-1:0]   count_q, count_d, period_q, period_d, compare_q, compare_d, snap_q, snap_d;
    logic [PRESC_W-1:0] presc_q, presc_d, pcnt_q, pcnt_d;
    logic               ito_q, ito_d, cont_q, cont_d, pwm_en_q, pwm_en_d;
    logic               run_q, run_d, to_q, to_d, roe_q, roe_d, pwm_q, pwm_d;
    logic [31:0]        rdata_s;

    assign sel_s       = wr_s && (ch_sel_s == CH_W'(c));
    assign wr_status_s = sel_s && (reg_sel_s == 3'd0);
    assign wr_ctrl_s   = sel_s && (reg_sel_s == 3'd1);
    assign wr_period_s = sel_s && (reg_sel_s == 3'd2);
    assign wr_cmp_s    = sel_s && (reg_sel_s == 3'd3);
    assign wr_snap_s   = sel_s && (reg_sel_s == 3'd4);
    assign wr_presc_s  = sel_s && (reg_sel_s == 3'd5);
    assign start_s     = wr_ctrl_s && writedata[2];
    assign stop_s      = wr_ctrl_s && writedata[3];
    assign tick_s      = run_q && (pcnt_q == PRESC_ZERO);
    // A PERIOD write in the same cycle swallows the timeout.
    assign te_s        = tick_s && (count_q == CNT_ZERO) && !wr_period_s;

    always_comb begin
      count_d   = count_q;
      period_d  = period_q;
      compare_d = wr_cmp_s  ? writedata[CNT_W-1:0]   : compare_q;
      snap_d    = wr_snap_s ? count_q                : snap_q;
      presc_d   = wr_presc_s ? writedata[PRESC_W-1:0] : presc_q;
      pcnt_d    = pcnt_q;
      ito_d     = wr_ctrl_s ? writedata[0] : ito_q;
      cont_d    = wr_ctrl_s ? writedata[1] : cont_q;
      pwm_en_d  = wr_ctrl_s ? writedata[4] : pwm_en_q;
      run_d     = run_q;
      pwm_d     = pwm_en_q && run_q && (count_q < compare_q);

      if (wr_period_s) begin
        period_d = writedata[CNT_W-1:0];
        count_d  = writedata[CNT_W-1:0];
      end else if (tick_s) begin
        count_d = (count_q == CNT_ZERO) ? period_q : (count_q - CNT_ONE);
      end else begin
        count_d = count_q;
      end

      if (wr_period_s || (start_s && !stop_s)) begin
        pcnt_d = presc_q;
      end else if (run_q) begin
        pcnt_d = (pcnt_q == PRESC_ZERO) ? presc_q : (pcnt_q - PRESC_ONE);
      end else begin
        pcnt_d = pcnt_q;
      end

      if (wr_period_s || stop_s) begin
        run_d = 1'b0;
      end else if (start_s) begin
        run_d = 1'b1;
      end else if (te_s && !cont_q) begin
        run_d = 1'b0;
      end else begin
        run_d = run_q;
      end

      if (te_s) begin
        to_d = 1'b1;
      end else if (wr_status_s) begin
        to_d = 1'b0;
      end else begin
        to_d = to_q;
      end

      if (wr_status_s) begin
        roe_d = 1'b0;
      end else if (te_s && to_q) begin
        roe_d = 1'b1;
      end else begin
        roe_d = roe_q;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        count_q   <= RST_CNT;
        period_q  <= RST_CNT;
        compare_q <= CNT_ZERO;
        snap_q    <= CNT_ZERO;
        presc_q   <= PRESC_ZERO;
        pcnt_q    <= PRESC_ZERO;
        ito_q     <= 1'b0;
        cont_q    <= 1'b0;
        pwm_en_q  <= 1'b0;
        run_q     <= 1'b0;
        to_q      <= 1'b0;
        roe_q     <= 1'b0;
        pwm_q     <= 1'b0;
      end else begin
        count_q   <= count_d;
        period_q  <= period_d;
        compare_q <= compare_d;
        snap_q    <= snap_d;
        presc_q   <= presc_d;
        pcnt_q    <= pcnt_d;
        ito_q     <= ito_d;
        cont_q    <= cont_d;
        pwm_en_q  <= pwm_en_d;
        run_q     <= run_d;
        to_q      <= to_d;
        roe_q     <= roe_d;
        pwm_q     <= pwm_d;
      end
    end

    always_comb begin
      case (reg_sel_s)
        3'd0:    rdata_s = {29'd0, roe_q, run_q, to_q};
        3'd1:    rdata_s = {27'd0, pwm_en_q, 2'b00, cont_q, ito_q};
        3'd2:    rdata_s = 32'(period_q);
        3'd3:    rdata_s = 32'(compare_q);
        3'd4:    rdata_s = 32'(snap_q);
        3'd5:    rdata_s = 32'(presc_q);
        default: rdata_s = 32'd0;
      endcase
    end

    assign ch_rdata_s[c] = rdata_s;
    assign irq_vec[c]    = to_q & ito_q;
    assign pwm_out[c]    = pwm_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_q <= 32'd0;
    end else begin
      readdata_q <= rd_sel_s;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |irq_vec;

endmodule

// File: tb/tb_avalon_multi_timer.sv
// Directed bench for avalon_multi_timer: register-map vector table plus hand-timed
// sequences for timeout latency, one-shot, overrun, PWM duty and mid-count reset.
module tb_avalon_multi_timer;

  localparam int ST = 0, CT = 1, PE = 2, CM = 3, SN = 4, PS = 5;

  logic        clk = 1'b0;
  logic        reset, chipselect, write_n, read_n;
  logic [4:0]  address;
  logic [31:0] writedata, readdata;
  logic        irq;
  logic [3:0]  irq_vec, pwm_out;

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[$];

  avalon_multi_timer #(.NUM_CH(4), .CNT_W(32), .PRESC_W(8), .RESET_PERIOD(49999)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata),
    .irq(irq), .irq_vec(irq_vec), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [4:0] A(input int ch, input int r);
    return 5'(ch * 8 + r);
  endfunction

  function automatic logic pick(input int idx);
    return (idx < 0) ? irq : irq_vec[idx];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    @(posedge clk); #1;
    d = readdata;
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic rd_chk(input string nm, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(nm, d, exp);
  endtask

  // Write, keep the address, and return what readdata shows one clock after the write.
  task automatic wr_peek(input logic [4:0] a, input logic [31:0] d, output logic [31:0] q);
    wr(a, d);
    @(posedge clk); #1;
    q = readdata;
  endtask

  task automatic wait_rise(input int idx, input int limit, output int at);
    bit done = 1'b0;
    at = -1;
    for (int k = 0; k < limit && !done; k++) begin
      @(posedge clk); #1;
      if (pick(idx)) begin
        at = cyc;
        done = 1'b1;
      end
    end
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic count_pwm(input int ch, input int n, output int highs);
    highs = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (pwm_out[ch]) highs++;
    end
  endtask

  task automatic add(input logic we, input logic [4:0] a, input logic [31:0] d,
                     input logic [31:0] e, input string nm);
    vec_t v;
    v.we = we; v.addr = a; v.wdata = d; v.exp = e; v.name = nm;
    vecs.push_back(v);
  endtask

  initial begin
    int t0, at, highs;
    logic [31:0] q;

    add(1'b0, A(0, PE), 32'd0,          32'd49999,      "rst_period0");
    add(1'b0, A(0, ST), 32'd0,          32'd0,          "rst_status0");
    add(1'b0, A(3, CT), 32'd0,          32'd0,          "rst_ctrl3");
    add(1'b0, A(2, CM), 32'd0,          32'd0,          "rst_cmp2");
    add(1'b0, A(1, PS), 32'd0,          32'd0,          "rst_presc1");
    add(1'b1, A(1, CM), 32'h0000_1234,  32'd0,          "");
    add(1'b0, A(1, CM), 32'd0,          32'h0000_1234,  "cmp1");
    add(1'b1, A(1, PS), 32'h0000_01FF,  32'd0,          "");
    add(1'b0, A(1, PS), 32'd0,          32'h0000_00FF,  "presc_trunc");
    add(1'b1, A(1, CT), 32'h0000_001F,  32'd0,          "");
    add(1'b0, A(1, CT), 32'd0,          32'h0000_0013,  "ctrl_fields");
    add(1'b0, A(1, ST), 32'd0,          32'd0,          "start_stop_tbl");
    add(1'b1, A(2, 6),  32'h0000_FFFF,  32'd0,          "");
    add(1'b0, A(2, 6),  32'd0,          32'd0,          "reg6");
    add(1'b0, A(2, 7),  32'd0,          32'd0,          "reg7");
    add(1'b1, A(0, PE), 32'hDEAD_BEEF,  32'd0,          "");
    add(1'b0, A(0, PE), 32'd0,          32'hDEAD_BEEF,  "period0");
    add(1'b1, A(0, SN), 32'd0,          32'd0,          "");
    add(1'b0, A(0, SN), 32'd0,          32'hDEAD_BEEF,  "snap0");
    add(1'b1, A(1, CT), 32'd0,          32'd0,          "");
    add(1'b0, A(1, CT), 32'd0,          32'd0,          "ctrl_clear");

    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
    address = 5'd0; writedata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_irq_vec", {28'd0, irq_vec}, 32'd0);
    chk("rst_pwm", {28'd0, pwm_out}, 32'd0);

    foreach (vecs[i]) begin
      if (vecs[i].we) wr(vecs[i].addr, vecs[i].wdata);
      else            rd_chk(vecs[i].name, vecs[i].addr, vecs[i].exp);
    end

    // ch0: continuous, 10-clock timeout interval
    wr(A(0, PE), 32'd9);
    wr(A(0, CT), 32'h07);
    t0 = cyc;
    wait_rise(-1, 40, at);
    chk("irq_first", at - t0, 32'd10);
    wr(A(0, ST), 32'd0);
    chk("irq_clear", {31'd0, irq}, 32'd0);
    wait_rise(-1, 40, at);
    chk("irq_second", at - t0, 32'd20);
    wr(A(0, ST), 32'd0);
    wait_until(t0 + 29);
    wr(A(0, PE), 32'd50);
    rd_chk("period_wr_status", A(0, ST), 32'd0);
    chk("period_wr_irq", {31'd0, irq}, 32'd0);
    wr(A(0, SN), 32'd0);
    rd_chk("period_wr_count", A(0, SN), 32'd50);
    wr(A(0, CT), 32'h0D);
    rd_chk("start_stop", A(0, ST), 32'd0);

    // ch1: one-shot with prescaler 3
    wr(A(1, PS), 32'd3);
    wr(A(1, PE), 32'd4);
    wr(A(1, CT), 32'h05);
    t0 = cyc;
    wait_rise(1, 60, at);
    chk("oneshot_latency", at - t0, 32'd20);
    repeat (30) @(posedge clk);
    rd_chk("oneshot_status", A(1, ST), 32'h1);
    wr(A(1, SN), 32'd0);
    rd_chk("oneshot_count", A(1, SN), 32'd4);
    wr(A(1, ST), 32'd0);

    // ch2: PERIOD 0 times out every tick
    wr(A(2, PE), 32'd0);
    wr(A(2, CT), 32'h06);
    repeat (3) @(posedge clk);
    wr(A(2, CT), 32'h0A);
    rd_chk("roe_set", A(2, ST), 32'h5);
    wr(A(2, ST), 32'd0);
    rd_chk("status_clear", A(2, ST), 32'd0);
    wr(A(2, CT), 32'h06);
    repeat (2) @(posedge clk);
    wr_peek(A(2, ST), 32'd0, q);
    chk("to_set_wins", q, 32'h3);
    wr(A(2, CT), 32'h0A);
    wr(A(2, ST), 32'd0);

    // ch3: PWM duty
    wr(A(3, CM), 32'd25);
    wr(A(3, PE), 32'd99);
    wr(A(3, CT), 32'h16);
    repeat (5) @(posedge clk);
    count_pwm(3, 200, highs);
    chk("pwm_25pct", highs, 32'd50);
    wr(A(3, CM), 32'd0);
    repeat (2) @(posedge clk);
    count_pwm(3, 100, highs);
    chk("pwm_cmp0", highs, 32'd0);
    wr(A(3, CM), 32'd200);
    repeat (2) @(posedge clk);
    count_pwm(3, 100, highs);
    chk("pwm_cmp_gt", highs, 32'd100);
    wr(A(3, CT), 32'h08);
    repeat (2) @(posedge clk); #1;
    chk("pwm_stopped", {28'd0, pwm_out}, 32'd0);

    // Reset mid-count, with a write presented during reset
    wr(A(0, CT), 32'h07);
    wr(A(3, CT), 32'h16);
    repeat (5) @(posedge clk); #1;
    chk("pwm_before_rst", {31'd0, pwm_out[3]}, 32'd1);
    @(negedge clk);
    reset = 1'b1; address = A(1, PE); writedata = 32'd7; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    chk("mid_rst_readdata", readdata, 32'd0);
    chk("mid_rst_irq", {31'd0, irq}, 32'd0);
    chk("mid_rst_pwm", {28'd0, pwm_out}, 32'd0);
    rd_chk("mid_rst_period0", A(0, PE), 32'd49999);
    rd_chk("mid_rst_period1", A(1, PE), 32'd49999);
    rd_chk("mid_rst_status0", A(0, ST), 32'd0);
    rd_chk("mid_rst_ctrl0", A(0, CT), 32'd0);
    rd_chk("mid_rst_cmp3", A(3, CM), 32'd0);
    rd_chk("mid_rst_presc1", A(1, PS), 32'd0);
    wr(A(0, SN), 32'd0);
    rd_chk("mid_rst_count0", A(0, SN), 32'd49999);
    wr(A(1, 6), 32'hFFFF_FFFF);
    rd_chk("mid_rst_reg6", A(1, 6), 32'd0);
    repeat (10) @(posedge clk); #1;
    chk("post_rst_pwm", {28'd0, pwm_out}, 32'd0);
    chk("post_rst_irq", {28'd0, irq_vec}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
